// File: rtl/bidir_bus_ctrl.sv
// ============================================================================
// bidir_bus_ctrl : half-duplex pad bus controller with turnaround and burst fairness
// Rev 1.0
// ============================================================================
`default_nettype none

module bidir_bus_ctrl #(
   parameter int WIDTH     = 8,
   parameter int TURN      = 2,
   parameter int RD_LAT    = 2,
   parameter int MAX_BURST = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_req,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ack,
   input  logic             rd_req,
   output logic             rd_ack,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [WIDTH-1:0] io_o,
   output logic             io_t,
   input  logic [WIDTH-1:0] io_i,
   output logic             bus_stb,
   output logic             bus_we
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TURN  = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_RWAIT = 3'd4
   } state_t;

   localparam logic [2:0] C_TURN_INIT  = 3'(TURN - 1);
   localparam logic [2:0] C_RWAIT_INIT = 3'(RD_LAT - 2);
   localparam logic [3:0] C_MAX_BURST  = 4'(MAX_BURST);

   state_t            state_q, state_d;
   logic              dir_q, dir_d;
   logic [3:0]        burst_q, burst_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              gnt_wr_q, gnt_wr_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic [WIDTH-1:0]  io_o_q, io_o_d;
   logic [WIDTH-1:0]  rd_data_q, rd_data_d;
   logic              io_t_q, io_t_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_ack_q, rd_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic              want_wr;

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      burst_d    = burst_q;
      cnt_d      = cnt_q;
      gnt_wr_d   = gnt_wr_q;
      io_o_d     = io_o_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      want_wr    = 1'b0;

      // One-hot-in-time tag per READ; the tag reaching the top marks the io_i sample cycle.
      pipe_d    = pipe_q << 1;
      pipe_d[0] = (state_q == ST_READ);
      if (pipe_q[RD_LAT-1]) begin
         rd_data_d  = io_i;
         rd_valid_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_req || rd_req) begin
               if (wr_req && rd_req) begin
                  want_wr = (burst_q == C_MAX_BURST) ? ~dir_q : dir_q;
               end else begin
                  want_wr = wr_req;
               end
               gnt_wr_d = want_wr;
               if (want_wr == dir_q) begin
                  state_d = want_wr ? ST_WRITE : ST_READ;
                  burst_d = (burst_q == C_MAX_BURST) ? burst_q : burst_q + 4'd1;
               end else begin
                  state_d = ST_TURN;
                  cnt_d   = C_TURN_INIT;
               end
            end
         end
         ST_TURN: begin
            if (cnt_q == 3'd0) begin
               // Counter restarts from zero and the pending grant is the first of the new burst.
               dir_d   = ~dir_q;
               burst_d = 4'd1;
               state_d = gnt_wr_q ? ST_WRITE : ST_READ;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_READ: begin
            if (RD_LAT == 1) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RWAIT;
               cnt_d   = C_RWAIT_INIT;
            end
         end
         ST_RWAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // WRITE always returns to IDLE, so a next state of WRITE is always an entry.
      if (state_d == ST_WRITE) begin
         io_o_d = wr_data;
      end

      stb_d    = (state_d == ST_WRITE) || (state_d == ST_READ);
      we_d     = (state_d == ST_WRITE);
      wr_ack_d = (state_d == ST_WRITE);
      rd_ack_d = (state_d == ST_READ);
      if (state_d == ST_WRITE) begin
         io_t_d = 1'b0;
      end else if (state_d == ST_IDLE) begin
         io_t_d = ~dir_d;
      end else begin
         io_t_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         dir_q      <= 1'b0;
         burst_q    <= 4'd0;
         cnt_q      <= 3'd0;
         gnt_wr_q   <= 1'b0;
         pipe_q     <= '0;
         io_o_q     <= '0;
         rd_data_q  <= '0;
         io_t_q     <= 1'b1;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         burst_q    <= burst_d;
         cnt_q      <= cnt_d;
         gnt_wr_q   <= gnt_wr_d;
         pipe_q     <= pipe_d;
         io_o_q     <= io_o_d;
         rd_data_q  <= rd_data_d;
         io_t_q     <= io_t_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         wr_ack_q   <= wr_ack_d;
         rd_ack_q   <= rd_ack_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign wr_ack   = wr_ack_q;
   assign rd_ack   = rd_ack_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign io_o     = io_o_q;
   assign io_t     = io_t_q;
   assign bus_stb  = stb_q;
   assign bus_we   = we_q;

endmodule

`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
// ============================================================================
// tb_bidir_bus_ctrl : directed and random bench for bidir_bus_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bidir_bus_ctrl;

   localparam int WIDTH     = 8;
   localparam int TURN      = 2;
   localparam int RD_LAT    = 2;
   localparam int MAX_BURST = 4;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             wr_req = 1'b0;
   logic             rd_req = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic [WIDTH-1:0] io_i = '0;
   logic             wr_ack, rd_ack, rd_valid, io_t, bus_stb, bus_we;
   logic [WIDTH-1:0] rd_data, io_o;
   logic [5:0]       ctrl_vec;

   bidir_bus_ctrl #(
      .WIDTH     (WIDTH),
      .TURN      (TURN),
      .RD_LAT    (RD_LAT),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .wr_req   (wr_req),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .rd_req   (rd_req),
      .rd_ack   (rd_ack),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .io_o     (io_o),
      .io_t     (io_t),
      .io_i     (io_i),
      .bus_stb  (bus_stb),
      .bus_we   (bus_we)
   );

   always #5 CLK = ~CLK;

   assign ctrl_vec = {io_t, bus_stb, bus_we, wr_ack, rd_ack, rd_valid};

   typedef struct {
      int               due;
      logic [WIDTH-1:0] data;
   } ent_t;

   ent_t             dev_q[$];
   ent_t             exp_rd[$];
   logic [WIDTH-1:0] exp_wr[$];

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   quiet    = 0;
   int   n_ack    = 0;
   int   n_req    = 0;
   int   wr_burst, turn_cnt;
   logic prev_stb  = 1'b0;
   logic prev_iot  = 1'b1;
   logic last_wack = 1'b0;
   logic last_rack = 1'b0;
   logic use_fixed = 1'b1;
   logic wr_act    = 1'b0;
   logic rd_act    = 1'b0;
   logic got_rd, prev_w;
   logic [7:0] tbl [15];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start of a cycle: advance the cycle index and let the device model drive io_i.
   task automatic cyc_start();
      @(posedge CLK);
      #1;
      cyc++;
      while (dev_q.size() > 0 && dev_q[0].due < cyc) dev_q.delete(0);
      if (dev_q.size() > 0 && dev_q[0].due == cyc) io_i = dev_q[0].data;
      else if (dev_q.size() > 0) io_i = ~dev_q[0].data;
      else io_i = WIDTH'($urandom);
   endtask

   // Mid-cycle: protocol invariants plus write/read scoreboards.
   task automatic cyc_end();
      ent_t e;
      @(negedge CLK);
      if (RST) begin
         dev_q.delete();
         exp_rd.delete();
         prev_stb  = 1'b0;
         prev_iot  = 1'b1;
         last_wack = 1'b0;
         last_rack = 1'b0;
         quiet     = 0;
         return;
      end
      check("ack_exclusive", 32'(wr_ack & rd_ack), 32'd0);
      if (bus_stb) begin
         check("stb_spacing", 32'(prev_stb), 32'd0);
         if (bus_we) check("wr_cycle", 32'({io_t, wr_ack, rd_ack}), 32'b010);
         else        check("rd_cycle", 32'({io_t, wr_ack, rd_ack}), 32'b101);
      end else begin
         check("ack_without_stb", 32'({wr_ack, rd_ack}), 32'd0);
      end
      if (!io_t && prev_iot) check("turnaround_len", 32'(quiet >= TURN), 32'd1);
      quiet = (io_t && !bus_stb) ? quiet + 1 : 0;
      if (wr_ack) begin
         n_ack++;
         check("wr_queue_nonempty", 32'(exp_wr.size() != 0), 32'd1);
         if (exp_wr.size() != 0) check("wr_data", 32'(io_o), 32'(exp_wr.pop_front()));
      end
      if (rd_ack) begin
         n_ack++;
         e.data = use_fixed ? 8'h3C : WIDTH'($urandom);
         e.due  = cyc + RD_LAT;
         dev_q.push_back(e);
         e.due  = cyc + RD_LAT + 1;
         exp_rd.push_back(e);
      end
      if (rd_valid) begin
         check("rd_queue_nonempty", 32'(exp_rd.size() != 0), 32'd1);
         if (exp_rd.size() != 0) begin
            e = exp_rd.pop_front();
            check("rd_valid_cycle", 32'(cyc), 32'(e.due));
            check("rd_data", 32'(rd_data), 32'(e.data));
         end
      end
      if (exp_rd.size() > 0) check("rd_valid_late", 32'(exp_rd[0].due >= cyc), 32'd1);
      prev_stb  = bus_stb;
      prev_iot  = io_t;
      last_wack = wr_ack;
      last_rack = rd_ack;
   endtask

   // Random requesters: hold until ack, then either re-request or drop.
   task automatic drive_reqs(input bit allow_new);
      if (wr_act && last_wack) begin
         if (allow_new && $urandom_range(1, 0) == 1) begin
            wr_data = WIDTH'($urandom);
            exp_wr.push_back(wr_data);
            n_req++;
         end else begin
            wr_req = 1'b0;
            wr_act = 1'b0;
         end
      end else if (!wr_act && allow_new && $urandom_range(2, 0) == 0) begin
         wr_data = WIDTH'($urandom);
         exp_wr.push_back(wr_data);
         wr_req = 1'b1;
         wr_act = 1'b1;
         n_req++;
      end
      if (rd_act && last_rack) begin
         if (allow_new && $urandom_range(1, 0) == 1) n_req++;
         else begin
            rd_req = 1'b0;
            rd_act = 1'b0;
         end
      end else if (!rd_act && allow_new && $urandom_range(2, 0) == 0) begin
         rd_req = 1'b1;
         rd_act = 1'b1;
         n_req++;
      end
   endtask

   initial begin
      // {wr_req, rd_req, io_t, bus_stb, bus_we, wr_ack, rd_ack, rd_valid} per cycle after reset
      tbl = '{8'b10_100000, 8'b00_100000, 8'b00_100000, 8'b00_011100, 8'b00_000000,
              8'b01_000000, 8'b00_100000, 8'b00_100000, 8'b00_110010, 8'b10_100000,
              8'b10_100000, 8'b00_100001, 8'b00_100000, 8'b00_011100, 8'b00_000000};

      for (int i = 0; i < 3; i++) begin
         cyc_start();
         cyc_end();
      end
      check("rst_ctrl", 32'(ctrl_vec), 32'b100000);
      check("rst_io_o", 32'(io_o), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);

      // First write pays a turnaround, read after it turns again, write after read turns back.
      prev_w = 1'b0;
      for (int i = 0; i < 15; i++) begin
         cyc_start();
         if (i == 0) RST = 1'b0;
         wr_data = (i < 5) ? 8'hA5 : 8'h5A;
         if (tbl[i][7] && !prev_w) exp_wr.push_back(wr_data);
         prev_w = tbl[i][7];
         wr_req = tbl[i][7];
         rd_req = tbl[i][6];
         cyc_end();
         check($sformatf("seq_c%0d", i), 32'(ctrl_vec), 32'(tbl[i][5:0]));
         if (i == 11) check("rd_data_3C", 32'(rd_data), 32'h3C);
      end

      // Both sides held with dir=1: the write just done plus three more, then turnaround, then READ.
      use_fixed = 1'b0;
      cyc_start();
      wr_req  = 1'b1;
      rd_req  = 1'b1;
      wr_data = 8'h11;
      exp_wr.push_back(wr_data);
      cyc_end();
      wr_burst = 1;
      turn_cnt = 0;
      got_rd   = 1'b0;
      for (int i = 0; i < 40 && !got_rd; i++) begin
         cyc_start();
         if (last_wack) begin
            wr_data = wr_data + 8'd1;
            exp_wr.push_back(wr_data);
         end
         cyc_end();
         if (wr_ack) begin
            wr_burst++;
            turn_cnt = 0;
         end else if (rd_ack) got_rd = 1'b1;
         else if (io_t && !bus_stb) turn_cnt++;
      end
      check("burst_read_seen", 32'(got_rd), 32'd1);
      check("burst_writes", 32'(wr_burst), 32'(MAX_BURST));
      check("burst_turn", 32'(turn_cnt), 32'(TURN));
      cyc_start();
      wr_req = 1'b0;
      rd_req = 1'b0;
      if (exp_wr.size() > 0) exp_wr.delete(exp_wr.size() - 1);
      cyc_end();
      for (int i = 0; i < 6; i++) begin
         cyc_start();
         cyc_end();
      end

      // Reset landing in RWAIT discards the pending capture.
      cyc_start();
      rd_req = 1'b1;
      cyc_end();
      cyc_start();
      rd_req = 1'b0;
      cyc_end();
      check("pre_rst_rd_ack", 32'(rd_ack), 32'd1);
      cyc_start();
      RST = 1'b1;
      cyc_end();
      cyc_start();
      RST = 1'b0;
      cyc_end();
      check("rwait_rst_ctrl", 32'(ctrl_vec), 32'b100000);
      check("rwait_rst_io_o", 32'(io_o), 32'd0);
      check("rwait_rst_rd_data", 32'(rd_data), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc_start();
         cyc_end();
         check("no_rd_valid_after_rst", 32'(rd_valid), 32'd0);
      end

      // Random traffic.
      n_ack = 0;
      n_req = 0;
      for (int i = 0; i < 10000; i++) begin
         cyc_start();
         drive_reqs(1'b1);
         cyc_end();
      end
      for (int i = 0; i < 60 && (wr_act || rd_act); i++) begin
         cyc_start();
         drive_reqs(1'b0);
         cyc_end();
      end
      check("drain_timeout", 32'(wr_act || rd_act), 32'd0);
      for (int i = 0; i < 6; i++) begin
         cyc_start();
         cyc_end();
      end
      check("ack_count", 32'(n_ack), 32'(n_req));
      check("rd_pending", 32'(exp_rd.size()), 32'd0);
      check("wr_pending", 32'(exp_wr.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bidir_bus_ctrl.md
BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK, with all state updating on the rising edge.
REQ-002 The block SHALL have reset RST, synchronous and active-high.
REQ-003 Parameter WIDTH, default 8: width of the pad data bus.
REQ-004 Parameter TURN, default 2, range 1-7: bus turnaround cycles on any direction change.
REQ-005 Parameter RD_LAT, default 2, range 1-7: cycles from read strobe to the io_i sample.
REQ-006 Parameter MAX_BURST, default 4, range 1-15: consecutive same-direction grants allowed while the other side waits.
REQ-007 Ports:
- CLK in 1: clock
- RST in 1: sync reset
- wr_req in 1: write request
- wr_data in WIDTH: write data, stable while wr_req=1
- wr_ack out 1: one-cycle write-done pulse
- rd_req in 1: read request
- rd_ack out 1: one-cycle read-strobe-issued pulse
- rd_data out WIDTH: captured read data
- rd_valid out 1: one-cycle rd_data-valid pulse
- io_o out WIDTH: to IOBUF I pins
- io_t out 1: to IOBUF T pins, 1=high-Z
- io_i in WIDTH: from IOBUF O pins
- bus_stb out 1: device strobe
- bus_we out 1: device write enable, qualified by bus_stb

Function
REQ-008 All outputs SHALL be registered.
REQ-009 FSM states SHALL be IDLE, TURN, WRITE, READ, RWAIT.
REQ-010 Register dir SHALL hold the bus owner: 1=controller drives, 0=released. In IDLE, io_t SHALL equal ~dir.
REQ-011 Arbitration SHALL happen in IDLE only.
- Single request pending: grant it.
- Both pending: grant the direction equal to dir, unless burst_cnt=MAX_BURST, in which case grant the other direction.
REQ-012 If the granted direction equals dir, the next state SHALL be WRITE or READ. Otherwise it SHALL be TURN.
REQ-013 TURN SHALL last exactly TURN cycles with io_t=1 and bus_stb=0. On exit, dir SHALL flip, burst_cnt SHALL clear, and the FSM SHALL enter WRITE or READ.
REQ-014 The grant decision SHALL be latched at the IDLE exit. Request changes during TURN SHALL be ignored.
REQ-015 On entry to WRITE, io_o SHALL load wr_data.
REQ-016 WRITE SHALL last 1 cycle with io_t=0, bus_stb=1, bus_we=1 and wr_ack=1, then go to IDLE.
REQ-017 READ SHALL last 1 cycle with io_t=1, bus_stb=1, bus_we=0 and rd_ack=1.
REQ-018 After READ, the FSM SHALL stay in RWAIT for RD_LAT-1 cycles, then go to IDLE. With RD_LAT=1, it SHALL go directly to IDLE.
REQ-019 io_i SHALL be sampled exactly RD_LAT cycles after the READ cycle. rd_data SHALL update and rd_valid SHALL pulse on the following cycle.
REQ-020 Each WRITE or READ grant SHALL increment burst_cnt, saturating at MAX_BURST.
REQ-021 Write and read sustained throughput SHALL be at most one transfer per 2 cycles (WRITE/READ then IDLE).
REQ-022 A requester holding its request high after its ack SHALL be treated as a new request at the next IDLE.
REQ-023 io_o SHALL hold its last value when not in WRITE.
REQ-024 At most one of wr_ack and rd_ack SHALL be asserted in any cycle.
REQ-025 bus_stb SHALL never be asserted in TURN or IDLE.

Reset
REQ-026 While RST=1, the block SHALL set: state=IDLE, dir=0, burst_cnt=0, io_t=1, io_o=0, bus_stb=0, bus_we=0, wr_ack=0, rd_ack=0, rd_valid=0, rd_data=0.
REQ-027 Reset mid-operation SHALL abort any TURN, WRITE or RWAIT. A pending read capture SHALL be discarded, with no rd_valid after RST.
REQ-028 The first write after reset SHALL pay a TURN-cycle turnaround.

Verification
REQ-029 Reset, then wr_req=1 with wr_data=0xA5 for 1 cycle: io_t stays 1 for 2 TURN cycles; in the WRITE cycle io_o=0xA5, io_t=0, bus_stb=1, bus_we=1, wr_ack=1; IDLE follows with io_t=0.
REQ-030 Read with RD_LAT=2, device drives io_i=0x3C two cycles after bus_stb: rd_ack in the READ cycle; rd_valid=1 with rd_data=0x3C three cycles after READ.
REQ-031 dir=1, wr_req and rd_req both held high: exactly 4 WRITE grants, then 2 TURN cycles, then READ.
REQ-032 Write directly after a read: io_t=1 for exactly TURN cycles between the READ/RWAIT end and WRITE, with no cycle where io_t=0 before TURN completes.
REQ-033 RST asserted during RWAIT: all outputs match the reset values the next cycle, and no rd_valid occurs within 10 cycles with no requests.
REQ-034 Random wr_req/rd_req for 10k cycles: the checker confirms REQ-024, REQ-025, no bus_stb during TURN, and an ack count equal to the granted request count.
